// File: rtl/sy_axi_sram_bridge_if.sv
// AXI4 channel bundle between the L2 cache port (master) and the SRAM bridge (slave).
// Addresses are fixed at 64 bits; ID and data widths are parameters.
interface sy_axi_sram_bridge_if #(
  parameter int unsigned ID_WTH   = 4,
  parameter int unsigned DATA_WTH = 64
);
  localparam int unsigned ADDR_WTH = 64;

  logic                  aw_valid;
  logic                  aw_ready;
  logic [ID_WTH-1:0]     aw_id;
  logic [ADDR_WTH-1:0]   aw_addr;
  logic [7:0]            aw_len;
  logic [2:0]            aw_size;
  logic [1:0]            aw_burst;

  logic                  ar_valid;
  logic                  ar_ready;
  logic [ID_WTH-1:0]     ar_id;
  logic [ADDR_WTH-1:0]   ar_addr;
  logic [7:0]            ar_len;
  logic [2:0]            ar_size;
  logic [1:0]            ar_burst;

  logic                  w_valid;
  logic                  w_ready;
  logic [DATA_WTH-1:0]   w_data;
  logic [DATA_WTH/8-1:0] w_strb;
  logic                  w_last;

  logic                  b_valid;
  logic                  b_ready;
  logic [ID_WTH-1:0]     b_id;
  logic [1:0]            b_resp;

  logic                  r_valid;
  logic                  r_ready;
  logic [ID_WTH-1:0]     r_id;
  logic [DATA_WTH-1:0]   r_data;
  logic [1:0]            r_resp;
  logic                  r_last;

  modport master (
    output aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    input  aw_ready,
    output ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    input  ar_ready,
    output w_valid, w_data, w_strb, w_last,
    input  w_ready,
    input  b_valid, b_id, b_resp,
    output b_ready,
    input  r_valid, r_id, r_data, r_resp, r_last,
    output r_ready
  );

  modport slave (
    input  aw_valid, aw_id, aw_addr, aw_len, aw_size, aw_burst,
    output aw_ready,
    input  ar_valid, ar_id, ar_addr, ar_len, ar_size, ar_burst,
    output ar_ready,
    input  w_valid, w_data, w_strb, w_last,
    output w_ready,
    output b_valid, b_id, b_resp,
    input  b_ready,
    output r_valid, r_id, r_data, r_resp, r_last,
    input  r_ready
  );
endinterface

// File: rtl/sy_axi_sram_bridge.sv
// AXI4 slave terminating the L2 external port onto a single-port word-addressed SRAM.
// One transaction at a time; reads and writes alternate when both are pending.
module sy_axi_sram_bridge #(
  parameter int unsigned DATA_WTH  = 64,
  parameter int unsigned MEM_WORDS = 65536,
  parameter logic [63:0] BASE_ADDR = 64'h8000_0000,
  parameter int unsigned MEM_AW    = 16,
  parameter int unsigned ID_WTH    = 4
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  sy_axi_sram_bridge_if.slave   axi,
  output logic                  mem_req_o,
  output logic                  mem_we_o,
  output logic [MEM_AW-1:0]     mem_addr_o,
  output logic [DATA_WTH-1:0]   mem_wdata_o,
  output logic [DATA_WTH/8-1:0] mem_be_o,
  input  logic [DATA_WTH-1:0]   mem_rdata_i
);

  localparam int unsigned ByteShift  = $clog2(DATA_WTH / 8);
  localparam logic [63:0] MemBytes   = 64'(MEM_WORDS) << ByteShift;
  localparam logic [63:0] EndAddr    = BASE_ADDR + MemBytes;
  localparam logic [1:0]  RespOkay   = 2'b00;
  localparam logic [1:0]  RespSlvErr = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StWrData,
    StWrResp,
    StRdReq,
    StRdWait,
    StRdData
  } state_e;

  state_e              state_q;
  logic                prio_rd_q;
  logic [ID_WTH-1:0]   id_q;
  logic [63:0]         addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [7:0]          beat_q;
  logic                err_q;
  logic                beat_err_q;
  logic                r_valid_q;
  logic [DATA_WTH-1:0] r_data_q;
  logic [1:0]          r_resp_q;
  logic                r_last_q;
  logic                b_valid_q;

  logic        in_range;
  logic        last_beat;
  logic        rsv_burst;
  logic        aw_grant;
  logic        ar_grant;
  logic        w_fire;
  logic [63:0] offset;
  logic [63:0] step;
  logic [63:0] wrap_mask;
  logic [63:0] next_addr;

  assign in_range   = (addr_q >= BASE_ADDR) && (addr_q < EndAddr);
  assign last_beat  = (beat_q == len_q);
  assign rsv_burst  = (burst_q == 2'b11);
  assign offset     = addr_q - BASE_ADDR;
  assign mem_addr_o = MEM_AW'(offset >> ByteShift);
  assign step       = 64'd1 << size_q;
  assign wrap_mask  = ((64'(len_q) + 64'd1) << size_q) - 64'd1;

  always_comb begin
    next_addr = addr_q + step;
    case (burst_q)
      2'b00:   next_addr = addr_q;
      // Keep the upper bits of the window, wrap the low bits.
      2'b10:   next_addr = (addr_q & ~wrap_mask) | ((addr_q + step) & wrap_mask);
      default: next_addr = addr_q + step;
    endcase
  end

  // Ready gated by rst_i so nothing handshakes while reset is held.
  assign aw_grant = rst_i && (state_q == StIdle) && axi.aw_valid &&
                    (!axi.ar_valid || !prio_rd_q);
  assign ar_grant = rst_i && (state_q == StIdle) && axi.ar_valid &&
                    (!axi.aw_valid || prio_rd_q);
  assign w_fire   = (state_q == StWrData) && axi.w_valid;

  assign axi.aw_ready = aw_grant;
  assign axi.ar_ready = ar_grant;
  assign axi.w_ready  = (state_q == StWrData);
  assign axi.b_valid  = b_valid_q;
  assign axi.b_id     = id_q;
  assign axi.b_resp   = (err_q || rsv_burst) ? RespSlvErr : RespOkay;
  assign axi.r_valid  = r_valid_q;
  assign axi.r_id     = id_q;
  assign axi.r_data   = r_data_q;
  assign axi.r_resp   = r_resp_q;
  assign axi.r_last   = r_last_q;

  assign mem_we_o    = w_fire && in_range;
  assign mem_req_o   = mem_we_o || ((state_q == StRdReq) && in_range);
  assign mem_wdata_o = mem_we_o ? axi.w_data : '0;
  assign mem_be_o    = mem_we_o ? axi.w_strb : '0;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      state_q    <= StIdle;
      prio_rd_q  <= 1'b1;
      id_q       <= '0;
      addr_q     <= '0;
      len_q      <= '0;
      size_q     <= '0;
      burst_q    <= '0;
      beat_q     <= '0;
      err_q      <= 1'b0;
      beat_err_q <= 1'b0;
      r_valid_q  <= 1'b0;
      r_data_q   <= '0;
      r_resp_q   <= RespOkay;
      r_last_q   <= 1'b0;
      b_valid_q  <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (aw_grant) begin
            id_q    <= axi.aw_id;
            addr_q  <= axi.aw_addr;
            len_q   <= axi.aw_len;
            size_q  <= axi.aw_size;
            burst_q <= axi.aw_burst;
            beat_q  <= '0;
            err_q   <= 1'b0;
            state_q <= StWrData;
          end else if (ar_grant) begin
            id_q    <= axi.ar_id;
            addr_q  <= axi.ar_addr;
            len_q   <= axi.ar_len;
            size_q  <= axi.ar_size;
            burst_q <= axi.ar_burst;
            beat_q  <= '0;
            err_q   <= 1'b0;
            state_q <= StRdReq;
          end
        end
        StWrData: begin
          if (axi.w_valid) begin
            // The beat count ends the burst; w_last only flags disagreement.
            if (!in_range || (axi.w_last != last_beat)) begin
              err_q <= 1'b1;
            end
            if (last_beat) begin
              b_valid_q <= 1'b1;
              state_q   <= StWrResp;
            end else begin
              addr_q <= next_addr;
              beat_q <= beat_q + 8'd1;
            end
          end
        end
        StWrResp: begin
          if (axi.b_ready) begin
            b_valid_q <= 1'b0;
            prio_rd_q <= 1'b1;
            state_q   <= StIdle;
          end
        end
        StRdReq: begin
          beat_err_q <= !in_range;
          state_q    <= StRdWait;
        end
        StRdWait: begin
          r_data_q  <= beat_err_q ? '0 : mem_rdata_i;
          r_resp_q  <= (beat_err_q || rsv_burst) ? RespSlvErr : RespOkay;
          r_last_q  <= last_beat;
          r_valid_q <= 1'b1;
          state_q   <= StRdData;
        end
        StRdData: begin
          if (axi.r_ready) begin
            r_valid_q <= 1'b0;
            if (r_last_q) begin
              prio_rd_q <= 1'b0;
              state_q   <= StIdle;
            end else begin
              addr_q  <= next_addr;
              beat_q  <= beat_q + 8'd1;
              state_q <= StRdReq;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_sy_axi_sram_bridge.sv
// Directed bench for sy_axi_sram_bridge: SRAM model, shadow memory and R/B scoreboards.
module tb_sy_axi_sram_bridge;
  localparam int unsigned MemWords = 65536;
  localparam logic [63:0] Base     = 64'h8000_0000;
  localparam int          Tmo      = 40;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  sy_axi_sram_bridge_if #(.ID_WTH(4), .DATA_WTH(64)) axi ();

  logic        mem_req, mem_we;
  logic [15:0] mem_addr;
  logic [63:0] mem_wdata, mem_rdata;
  logic [7:0]  mem_be;

  sy_axi_sram_bridge #(
    .DATA_WTH(64), .MEM_WORDS(MemWords), .BASE_ADDR(Base), .MEM_AW(16), .ID_WTH(4)
  ) dut (
    .clk_i      (clk),
    .rst_i      (rst_n),
    .axi        (axi),
    .mem_req_o  (mem_req),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_be_o   (mem_be),
    .mem_rdata_i(mem_rdata)
  );

  logic [63:0] sram    [MemWords];
  logic [63:0] ref_mem [MemWords];
  logic [15:0] rd_log  [$];
  int          we_count = 0;

  always @(posedge clk) begin
    if (mem_req) begin
      if (mem_we) begin
        for (int b = 0; b < 8; b++) if (mem_be[b]) sram[mem_addr][8*b +: 8] = mem_wdata[8*b +: 8];
        we_count++;
      end else begin
        mem_rdata <= sram[mem_addr];
        rd_log.push_back(mem_addr);
      end
    end
  end

  typedef struct packed {
    logic [63:0] data;
    logic [1:0]  resp;
    logic        last;
  } rexp_t;

  rexp_t      r_q [$];
  logic [5:0] b_q [$];  // {id, resp}
  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic in_rng(input logic [63:0] a);
    return (a >= Base) && (a < Base + 64'(MemWords) * 64'd8);
  endfunction

  function automatic logic [15:0] word_of(input logic [63:0] a);
    logic [63:0] w;
    w = (a - Base) / 64'd8;
    return w[15:0];
  endfunction

  function automatic logic [63:0] nxt(input logic [63:0] a, input logic [7:0] len,
                                      input logic [2:0] size, input logic [1:0] burst);
    logic [63:0] st, wb, lo;
    st = 64'd1 << size;
    wb = (64'(len) + 64'd1) * st;
    lo = (a / wb) * wb;
    case (burst)
      2'b00:   return a;
      2'b10:   return lo + ((a - lo + st) % wb);
      default: return a + st;
    endcase
  endfunction

  // Caller is at a negedge; returns at a negedge.
  task automatic axi_write(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                           input logic [1:0] burst, input logic [7:0] strb,
                           input logic [63:0] dbase, input logic bad_last, input int hold_b);
    logic [63:0] a;
    logic        err, stable;
    int          n;
    a   = addr;
    err = (burst == 2'b11) || bad_last;
    for (int i = 0; i <= int'(len); i++) begin
      if (in_rng(a)) begin
        for (int b = 0; b < 8; b++)
          if (strb[b]) ref_mem[word_of(a)][8*b +: 8] = (dbase + 64'(i)) >> (8*b);
      end else err = 1'b1;
      a = nxt(a, len, 3'd3, burst);
    end
    b_q.push_back({id, err ? 2'b10 : 2'b00});
    axi.aw_id = id; axi.aw_addr = addr; axi.aw_len = len; axi.aw_size = 3'd3;
    axi.aw_burst = burst; axi.aw_valid = 1'b1;
    #1;
    n = 0;
    while (!axi.aw_ready && n < Tmo) begin @(negedge clk); #1; n++; end
    chk("aw_ready_wait", 64'(n < Tmo), 1);
    @(posedge clk); @(negedge clk);
    axi.aw_valid = 1'b0;
    chk("aw_to_w_ready", axi.w_ready, 1);
    for (int i = 0; i <= int'(len); i++) begin
      axi.w_data  = dbase + 64'(i);
      axi.w_strb  = strb;
      axi.w_last  = (i == int'(len)) && !bad_last;
      axi.w_valid = 1'b1;
      #1;
      n = 0;
      while (!axi.w_ready && n < Tmo) begin @(negedge clk); #1; n++; end
      if (n >= Tmo) chk("w_ready_wait", 64'(n), 0);
      @(posedge clk); @(negedge clk);
    end
    axi.w_valid = 1'b0;
    chk("last_w_to_b_valid", axi.b_valid, 1);
    stable = 1'b1;
    repeat (hold_b) begin @(negedge clk); if (axi.b_valid !== 1'b1) stable = 1'b0; end
    if (hold_b > 0) chk("b_held", stable, 1);
    axi.b_ready = 1'b1;
    n = 0;
    while (!axi.b_valid && n < Tmo) begin @(negedge clk); n++; end
    chk("b_valid_wait", 64'(n < Tmo), 1);
    chk("b_id_resp", {axi.b_id, axi.b_resp}, b_q.pop_front());
    @(posedge clk); @(negedge clk);
    axi.b_ready = 1'b0;
    chk("b_valid_cleared", axi.b_valid, 0);
  endtask

  task automatic axi_read(input logic [3:0] id, input logic [63:0] addr, input logic [7:0] len,
                          input logic [1:0] burst, input int hold_r);
    logic [63:0] a;
    logic        stable;
    rexp_t       e, snap;
    int          n;
    a = addr;
    for (int i = 0; i <= int'(len); i++) begin
      e.data = in_rng(a) ? ref_mem[word_of(a)] : 64'd0;
      e.resp = (!in_rng(a) || burst == 2'b11) ? 2'b10 : 2'b00;
      e.last = (i == int'(len));
      r_q.push_back(e);
      a = nxt(a, len, 3'd3, burst);
    end
    axi.ar_id = id; axi.ar_addr = addr; axi.ar_len = len; axi.ar_size = 3'd3;
    axi.ar_burst = burst; axi.ar_valid = 1'b1;
    #1;
    n = 0;
    while (!axi.ar_ready && n < Tmo) begin @(negedge clk); #1; n++; end
    chk("ar_ready_wait", 64'(n < Tmo), 1);
    @(posedge clk); @(negedge clk);
    axi.ar_valid = 1'b0;
    @(negedge clk);
    chk("r_valid_early", axi.r_valid, 0);
    @(negedge clk);
    chk("ar_to_r_valid", axi.r_valid, 1);
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!axi.r_valid && n < Tmo) begin @(negedge clk); n++; end
      chk("r_valid_wait", 64'(n < Tmo), 1);
      if (i == 0 && hold_r > 0) begin
        snap   = {axi.r_data, axi.r_resp, axi.r_last};
        stable = 1'b1;
        repeat (hold_r) begin
          @(negedge clk);
          if (!axi.r_valid || {axi.r_data, axi.r_resp, axi.r_last} !== snap) stable = 1'b0;
        end
        chk("r_held", stable, 1);
      end
      e = r_q.pop_front();
      chk("r_data", axi.r_data, e.data);
      chk("r_resp", axi.r_resp, e.resp);
      chk("r_last", axi.r_last, e.last);
      chk("r_id", axi.r_id, id);
      axi.r_ready = 1'b1;
      @(posedge clk); @(negedge clk);
      axi.r_ready = 1'b0;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] wrap_exp [4];
    int          we0, bseen;
    wrap_exp = '{16'd3, 16'd0, 16'd1, 16'd2};
    for (int i = 0; i < int'(MemWords); i++) begin
      sram[i]    = {16'hC0DE, 16'(i), ~32'(i)};
      ref_mem[i] = sram[i];
    end
    for (int i = 32'h20; i < 32'h24; i++) begin
      sram[i]    = '1;
      ref_mem[i] = '1;
    end
    mem_rdata   = '0;
    axi.w_valid = 1'b0; axi.w_data = '0; axi.w_strb = '0; axi.w_last = 1'b0;
    axi.b_ready = 1'b0; axi.r_ready = 1'b0;
    // Both address channels valid while reset is held.
    axi.aw_id = 4'd2; axi.aw_addr = 64'h8000_0010; axi.aw_len = 8'd0; axi.aw_size = 3'd3;
    axi.aw_burst = 2'b01; axi.aw_valid = 1'b1;
    axi.ar_id = 4'd1; axi.ar_addr = 64'h8000_0040; axi.ar_len = 8'd0; axi.ar_size = 3'd3;
    axi.ar_burst = 2'b01; axi.ar_valid = 1'b1;
    repeat (2) @(negedge clk);
    chk("rst_ready", {axi.aw_ready, axi.ar_ready, axi.w_ready}, 0);
    chk("rst_valid", {axi.r_valid, axi.b_valid, mem_req, mem_we}, 0);
    rst_n = 1'b1;
    #1;
    chk("arb_first_read", {axi.ar_ready, axi.aw_ready}, 2'b10);
    axi_read(4'd1, 64'h8000_0040, 8'd0, 2'b01, 0);
    axi_write(4'd2, 64'h8000_0010, 8'd0, 2'b01, 8'hFF, 64'hDEAD_BEEF_0123_4567, 1'b0, 0);
    chk("single_sram", sram[2], 64'hDEAD_BEEF_0123_4567);
    axi_read(4'd3, 64'h8000_0010, 8'd0, 2'b01, 5);

    axi_write(4'd4, 64'h8000_0100, 8'd3, 2'b01, 8'h0F, 64'h1111_2222_3333_0000, 1'b0, 4);
    for (int i = 0; i < 4; i++) chk("incr_sram", sram[32'h20 + i], 64'hFFFF_FFFF_3333_0000 + 64'(i));
    axi_read(4'd5, 64'h8000_0100, 8'd3, 2'b01, 0);

    rd_log.delete();
    axi_read(4'd6, 64'h8000_0018, 8'd3, 2'b10, 0);
    chk("wrap_count", rd_log.size(), 4);
    for (int i = 0; i < 4 && i < rd_log.size(); i++) chk("wrap_word", rd_log[i], wrap_exp[i]);

    we0 = we_count;
    axi_write(4'd7, 64'h7FFF_FFF8, 8'd1, 2'b00, 8'hFF, 64'h5555_0000_0000_0000, 1'b0, 0);
    chk("oor_no_we", we_count - we0, 0);
    rd_log.delete();
    axi_read(4'd8, Base + 64'(MemWords) * 64'd8, 8'd0, 2'b01, 0);
    chk("oor_no_rd", rd_log.size(), 0);

    axi_write(4'd9, 64'h8000_0200, 8'd0, 2'b01, 8'hFF, 64'h0BAD_1A57_0000_0001, 1'b1, 0);
    chk("bad_last_sram", sram[16'h40], 64'h0BAD_1A57_0000_0001);

    // Reset in the middle of a 4-beat write burst.
    axi.aw_id = 4'd10; axi.aw_addr = 64'h8000_1000; axi.aw_len = 8'd3; axi.aw_size = 3'd3;
    axi.aw_burst = 2'b01; axi.aw_valid = 1'b1;
    #1;
    chk("mid_aw_ready", axi.aw_ready, 1);
    @(posedge clk); @(negedge clk);
    axi.aw_valid = 1'b0;
    axi.w_strb = 8'hFF; axi.w_last = 1'b0; axi.w_valid = 1'b1;
    for (int i = 0; i < 2; i++) begin
      axi.w_data = 64'h7777_0000 + 64'(i);
      @(posedge clk); @(negedge clk);
    end
    axi.ar_valid = 1'b1; axi.ar_addr = 64'h8000_0010; axi.ar_id = 4'd11;
    axi.ar_len = 8'd0; axi.ar_burst = 2'b01;
    rst_n = 1'b0;
    #1;
    chk("midrst_ready", {axi.aw_ready, axi.ar_ready, axi.w_ready}, 0);
    chk("midrst_valid", {axi.r_valid, axi.b_valid, mem_req, mem_we}, 0);
    axi.w_valid = 1'b0; axi.ar_valid = 1'b0;
    axi.b_ready = 1'b1;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    bseen = 0;
    repeat (10) begin @(negedge clk); if (axi.b_valid) bseen++; end
    chk("midrst_no_b", bseen, 0);
    axi.b_ready = 1'b0;
    axi_read(4'd11, 64'h8000_0010, 8'd0, 2'b01, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
